// File: rtl/axi_lite_master_port.sv
// Single-outstanding AXI4-Lite initiator bridging a core req/rsp handshake to AW/W/B or AR/R.
// Define AXI_MST_TIMEOUT_EN to bound the B/R wait by TIMEOUT_CYCLES.
module axi_lite_master_port #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic [1:0]  rsp_resp,
    output logic        timeout_err,
    output logic [31:0] M_AWADDR,
    output logic        M_AWVALID,
    input  logic        M_AWREADY,
    output logic [63:0] M_WDATA,
    output logic [7:0]  M_WSTRB,
    output logic        M_WVALID,
    input  logic        M_WREADY,
    input  logic [1:0]  M_BRESP,
    input  logic        M_BVALID,
    output logic        M_BREADY,
    output logic [31:0] M_ARADDR,
    output logic        M_ARVALID,
    input  logic        M_ARREADY,
    input  logic [63:0] M_RDATA,
    input  logic [1:0]  M_RRESP,
    input  logic        M_RVALID,
    output logic        M_RREADY
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_RESP = 3'd4,
        RSP     = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [7:0]  wstrb_q, wstrb_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;
    logic [63:0] rdata_q, rdata_d;
    logic [1:0]  resp_q, resp_d;
    logic        awvalid_q, awvalid_d;
    logic        wvalid_q, wvalid_d;
    logic        bready_q, bready_d;
    logic        arvalid_q, arvalid_d;
    logic        rready_q, rready_d;
    logic        req_ready_q, req_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        tmo_hit_s;
    logic        tmo_take_s;

    // Next-state and captured payload/response
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        rdata_d    = rdata_q;
        resp_d     = resp_q;
        tmo_take_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d    = req_addr;
                    wdata_d   = req_wdata;
                    wstrb_d   = req_wstrb;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = req_wen ? WR_REQ : RD_REQ;
                end else begin
                    state_d = IDLE;
                end
            end
            WR_REQ: begin
                // AW and W complete independently, possibly on the same edge
                if (awvalid_q && M_AWREADY) begin
                    aw_done_d = 1'b1;
                end else begin
                    aw_done_d = aw_done_q;
                end
                if (wvalid_q && M_WREADY) begin
                    w_done_d = 1'b1;
                end else begin
                    w_done_d = w_done_q;
                end
                if (aw_done_d && w_done_d) begin
                    state_d = WR_RESP;
                end else begin
                    state_d = WR_REQ;
                end
            end
            WR_RESP: begin
                if (M_BVALID) begin
                    resp_d  = M_BRESP;
                    rdata_d = 64'd0;
                    state_d = RSP;
                end else if (tmo_hit_s) begin
                    resp_d     = 2'b11;
                    rdata_d    = 64'd0;
                    tmo_take_s = 1'b1;
                    state_d    = RSP;
                end else begin
                    state_d = WR_RESP;
                end
            end
            RD_REQ: begin
                if (M_ARREADY) begin
                    state_d = RD_RESP;
                end else begin
                    state_d = RD_REQ;
                end
            end
            RD_RESP: begin
                if (M_RVALID) begin
                    resp_d  = M_RRESP;
                    rdata_d = M_RDATA;
                    state_d = RSP;
                end else if (tmo_hit_s) begin
                    resp_d     = 2'b11;
                    rdata_d    = 64'd0;
                    tmo_take_s = 1'b1;
                    state_d    = RSP;
                end else begin
                    state_d = RD_RESP;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = RSP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Interface outputs are decoded from the next state so they leave flops
    always_comb begin
        awvalid_d   = (state_d == WR_REQ) && !aw_done_d;
        wvalid_d    = (state_d == WR_REQ) && !w_done_d;
        bready_d    = (state_d == WR_RESP);
        arvalid_d   = (state_d == RD_REQ);
        rready_d    = (state_d == RD_RESP);
        req_ready_d = (state_d == IDLE);
        rsp_valid_d = (state_d == RSP);
    end

    // State, payload and output registers
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q     <= IDLE;
            addr_q      <= 32'd0;
            wdata_q     <= 64'd0;
            wstrb_q     <= 8'd0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            rdata_q     <= 64'd0;
            resp_q      <= 2'b00;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            rdata_q     <= rdata_d;
            resp_q      <= resp_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

`ifdef AXI_MST_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;
    logic        timeout_err_q;

    // Counter is zero on entry to a response wait and counts each cycle spent there
    always_comb begin
        if ((state_q == WR_RESP) || (state_q == RD_RESP)) begin
            cnt_d = cnt_q + 16'd1;
        end else begin
            cnt_d = 16'd0;
        end
    end

    assign tmo_hit_s = (cnt_q == 16'(TIMEOUT_CYCLES - 1));

    // Wait counter and sticky timeout flag
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            cnt_q         <= 16'd0;
            timeout_err_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            timeout_err_q <= timeout_err_q | tmo_take_s;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    logic unused_cfg_s;

    assign tmo_hit_s    = 1'b0;
    assign timeout_err  = 1'b0;
    assign unused_cfg_s = ^{tmo_take_s, 32'(TIMEOUT_CYCLES)};
`endif

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign rsp_resp  = resp_q;
    assign M_AWADDR  = addr_q;
    assign M_AWVALID = awvalid_q;
    assign M_WDATA   = wdata_q;
    assign M_WSTRB   = wstrb_q;
    assign M_WVALID  = wvalid_q;
    assign M_BREADY  = bready_q;
    assign M_ARADDR  = addr_q;
    assign M_ARVALID = arvalid_q;
    assign M_RREADY  = rready_q;

endmodule

// File: tb/tb_axi_lite_master_port.sv
// Scoreboard bench for axi_lite_master_port: directed requests, a configurable AXI-Lite responder,
// and a monitor that checks every presented response against the queued expectation.
module tb_axi_lite_master_port;

    logic        CLK = 1'b0;
    logic        RSTn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wen = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [63:0] req_wdata = 64'd0;
    logic [7:0]  req_wstrb = 8'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [63:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        timeout_err;
    logic [31:0] M_AWADDR;
    logic        M_AWVALID;
    logic        M_AWREADY = 1'b0;
    logic [63:0] M_WDATA;
    logic [7:0]  M_WSTRB;
    logic        M_WVALID;
    logic        M_WREADY = 1'b0;
    logic [1:0]  M_BRESP = 2'b00;
    logic        M_BVALID = 1'b0;
    logic        M_BREADY;
    logic [31:0] M_ARADDR;
    logic        M_ARVALID;
    logic        M_ARREADY = 1'b0;
    logic [63:0] M_RDATA = 64'd0;
    logic [1:0]  M_RRESP = 2'b00;
    logic        M_RVALID = 1'b0;
    logic        M_RREADY;

    always #5 CLK = ~CLK;

    axi_lite_master_port #(.TIMEOUT_CYCLES(16)) dut (
        .CLK(CLK), .RSTn(RSTn),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .timeout_err(timeout_err),
        .M_AWADDR(M_AWADDR), .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY),
        .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WVALID(M_WVALID), .M_WREADY(M_WREADY),
        .M_BRESP(M_BRESP), .M_BVALID(M_BVALID), .M_BREADY(M_BREADY),
        .M_ARADDR(M_ARADDR), .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
        .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RVALID(M_RVALID), .M_RREADY(M_RREADY)
    );

    typedef struct {
        logic [63:0] rdata;
        logic [1:0]  resp;
        int          lat;
        int          acc;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          last_acc = 0;
    logic [31:0] exp_addr = 32'd0;
    logic [63:0] exp_wdata = 64'd0;
    logic [7:0]  exp_wstrb = 8'd0;

    // responder configuration and bookkeeping
    int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    bit          no_b = 1'b0;
    logic [1:0]  s_bresp = 2'b00, s_rresp = 2'b00;
    logic [63:0] s_rdata = 64'd0;
    int          n_aw = 0, n_w = 0, n_b = 0, n_ar = 0;
    int          aw_cyc = 0, w_cyc = 0;
    bit          bready_seen = 1'b0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout required=event", name);
    endtask

    // Responder: drives READY/VALID at the falling edge; *_f flags predict the next rising edge
    initial begin
        int  aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
        bit  aw_got = 0, w_got = 0, ar_got = 0;
        bit  aw_f = 0, w_f = 0, b_f = 0, ar_f = 0, r_f = 0;
        bit  aw_pend = 0, w_pend = 0, ar_pend = 0;
        forever begin
            @(negedge CLK);
            if (!RSTn) begin
                M_AWREADY = 0; M_WREADY = 0; M_BVALID = 0; M_ARREADY = 0; M_RVALID = 0;
                aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
                aw_got = 0; w_got = 0; ar_got = 0;
                aw_f = 0; w_f = 0; b_f = 0; ar_f = 0; r_f = 0;
                aw_pend = 0; w_pend = 0; ar_pend = 0;
            end else begin
                if (aw_f) begin aw_got = 1; n_aw++; aw_cyc = cyc; end
                if (w_f) begin w_got = 1; n_w++; w_cyc = cyc; end
                if (b_f) begin n_b++; aw_got = 0; w_got = 0; end
                if (ar_f) begin ar_got = 1; n_ar++; end
                if (r_f) ar_got = 0;
                if (M_BREADY) bready_seen = 1;
                if (aw_pend) begin
                    chk("awvalid_held", M_AWVALID, 1);
                    chk("awaddr_held", M_AWADDR, exp_addr);
                end
                if (w_pend) begin
                    chk("wvalid_held", M_WVALID, 1);
                    chk("wdata_held", M_WDATA, exp_wdata);
                end
                if (ar_pend) begin
                    chk("arvalid_held", M_ARVALID, 1);
                    chk("araddr_held", M_ARADDR, exp_addr);
                end
                if (w_got && !aw_got) chk("wvalid_dropped", M_WVALID, 0);
                if (aw_got && !w_got) chk("awvalid_dropped", M_AWVALID, 0);

                if (M_AWVALID) begin M_AWREADY = (aw_cnt >= aw_dly); aw_cnt++; end
                else begin M_AWREADY = 0; aw_cnt = 0; end
                if (M_WVALID) begin M_WREADY = (w_cnt >= w_dly); w_cnt++; end
                else begin M_WREADY = 0; w_cnt = 0; end
                if (M_ARVALID) begin M_ARREADY = (ar_cnt >= ar_dly); ar_cnt++; end
                else begin M_ARREADY = 0; ar_cnt = 0; end
                if (aw_got && w_got && !no_b) begin
                    M_BVALID = (b_cnt >= b_dly); b_cnt++; M_BRESP = s_bresp;
                end else begin
                    M_BVALID = 0; b_cnt = 0;
                end
                if (ar_got) begin
                    M_RVALID = (r_cnt >= r_dly); r_cnt++; M_RDATA = s_rdata; M_RRESP = s_rresp;
                end else begin
                    M_RVALID = 0; r_cnt = 0;
                end

                aw_f = M_AWVALID && M_AWREADY;
                w_f  = M_WVALID && M_WREADY;
                b_f  = M_BVALID && M_BREADY;
                ar_f = M_ARVALID && M_ARREADY;
                r_f  = M_RVALID && M_RREADY;
                aw_pend = M_AWVALID && !aw_f;
                w_pend  = M_WVALID && !w_f;
                ar_pend = M_ARVALID && !ar_f;
                if (aw_f) chk("awaddr", M_AWADDR, exp_addr);
                if (w_f) begin
                    chk("wdata", M_WDATA, exp_wdata);
                    chk("wstrb", M_WSTRB, exp_wstrb);
                end
                if (ar_f) chk("araddr", M_ARADDR, exp_addr);
            end
        end
    end

    // Monitor: compares every presented response with the scoreboard head
    initial begin
        bit in_rsp = 0;
        int first_cyc = 0;
        forever begin
            @(negedge CLK);
            #1;
            if (!RSTn) begin
                in_rsp = 0;
            end else if (rsp_valid) begin
                chk("req_ready_busy", req_ready, 0);
                if (!in_rsp) begin in_rsp = 1; first_cyc = cyc; end
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected actual=rdata 0x%0h resp %0d required=no response",
                             rsp_rdata, rsp_resp);
                end else begin
                    chk("rsp_rdata", rsp_rdata, exp_q[0].rdata);
                    chk("rsp_resp", rsp_resp, exp_q[0].resp);
                    if (rsp_ready) begin
                        if (exp_q[0].lat > 0)
                            chk("latency", 64'(first_cyc - exp_q[0].acc), 64'(exp_q[0].lat));
                        void'(exp_q.pop_front());
                        in_rsp = 0;
                    end
                end
            end
        end
    end

    task automatic issue(input logic wen, input logic [31:0] a, input logic [63:0] d,
                         input logic [7:0] s, input logic [63:0] er, input logic [1:0] eresp,
                         input int lat);
        int   n = 0;
        exp_t e;
        @(negedge CLK);
        req_valid = 1; req_wen = wen; req_addr = a; req_wdata = d; req_wstrb = s;
        exp_addr = a; exp_wdata = d; exp_wstrb = s;
        while (!req_ready && n < 200) begin @(negedge CLK); n++; end
        if (!req_ready) begin
            fail("accept_wait");
            req_valid = 0;
        end else begin
            e.rdata = er; e.resp = eresp; e.lat = lat; e.acc = cyc;
            last_acc = cyc;
            exp_q.push_back(e);
            @(negedge CLK);
            req_valid = 0;
            req_addr = 32'hFFFF_FFFF; req_wdata = 64'hDEAD_BEEF_DEAD_BEEF; req_wstrb = 8'h00;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || !req_ready) && n < 300) begin @(negedge CLK); n++; end
        if (exp_q.size() != 0 || !req_ready) fail("idle_wait");
    endtask

    initial begin
        int n;
        int b0, aw0, w0, rel_cyc;
        RSTn = 0;
        repeat (3) @(negedge CLK);
        #1;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_valids", {M_AWVALID, M_WVALID, M_BREADY, M_ARVALID, M_RREADY, rsp_valid}, 6'd0);
        chk("rst_regs", {M_AWADDR, M_WDATA[31:0]}, 64'd0);
        chk("rst_rsp", {rsp_rdata[61:0], rsp_resp}, 64'd0);
        chk("rst_timeout", timeout_err, 0);
        RSTn = 1;

        // 1: zero-wait write
        b0 = n_b; bready_seen = 0;
        issue(1, 32'h2000_0000, 64'h41, 8'hFF, 64'd0, 2'b00, 3);
        wait_idle();
        chk("t1_aw_w_same_cycle", 64'(aw_cyc), 64'(w_cyc));
        chk("t1_bready_seen", bready_seen, 1);
        chk("t1_one_b", 64'(n_b - b0), 64'd1);

        // 2: read with delayed ARREADY and RVALID
        ar_dly = 2; r_dly = 5; s_rdata = 64'h0123_4567_89AB_CDEF; s_rresp = 2'b00;
        issue(0, 32'h2000_0008, 64'd0, 8'd0, 64'h0123_4567_89AB_CDEF, 2'b00, 0);
        wait_idle();
        ar_dly = 0; r_dly = 0;

        // 3: WREADY two cycles ahead of AWREADY, SLVERR response
        aw_dly = 2; s_bresp = 2'b10; b0 = n_b; aw0 = n_aw; w0 = n_w;
        issue(1, 32'h2000_0010, 64'h0000_0000_0000_CAFE, 8'h0F, 64'd0, 2'b10, 0);
        wait_idle();
        chk("t3_one_aw", 64'(n_aw - aw0), 64'd1);
        chk("t3_one_w", 64'(n_w - w0), 64'd1);
        chk("t3_one_b", 64'(n_b - b0), 64'd1);
        chk("t3_w_before_aw", 64'(aw_cyc - w_cyc), 64'd2);
        aw_dly = 0; s_bresp = 2'b00;

        // 4: consumer stalls the response; a second request must wait
        rsp_ready = 0; s_rdata = 64'h1122_3344_5566_7788; s_rresp = 2'b01; rel_cyc = 0;
        fork
            begin
                issue(0, 32'h2000_0100, 64'd0, 8'd0, 64'h1122_3344_5566_7788, 2'b01, 3);
                issue(0, 32'h2000_0108, 64'd0, 8'd0, 64'h1122_3344_5566_7788, 2'b01, 0);
            end
            begin
                n = 0;
                while (!rsp_valid && n < 100) begin @(negedge CLK); n++; end
                if (!rsp_valid) fail("t4_rsp_wait");
                repeat (4) @(negedge CLK);
                rel_cyc = cyc;
                rsp_ready = 1;
            end
        join
        wait_idle();
        chk("t4_second_waits", 64'(last_acc > rel_cyc), 64'd1);

        // 5: reset while waiting for B
        no_b = 1;
        issue(1, 32'h2000_0200, 64'h55, 8'h01, 64'd0, 2'b00, 0);
        n = 0;
        while (!M_BREADY && n < 50) begin @(negedge CLK); n++; end
        if (!M_BREADY) fail("t5_bready_wait");
        #2 RSTn = 0;
        #1 chk("t5_async_drop", {M_AWVALID, M_WVALID, M_BREADY, M_ARVALID, M_RREADY, rsp_valid}, 6'd0);
        exp_q.delete();
        repeat (2) @(negedge CLK);
        #2 RSTn = 1;
        no_b = 0;
        @(negedge CLK);
        #1 chk("t5_req_ready", req_ready, 1);
        s_rdata = 64'h0000_0000_0000_00A5; s_rresp = 2'b00;
        issue(0, 32'h2000_0300, 64'd0, 8'd0, 64'h0000_0000_0000_00A5, 2'b00, 3);
        wait_idle();

`ifdef AXI_MST_TIMEOUT_EN
        // 6: responder never answers the write
        no_b = 1;
        issue(1, 32'h2000_0400, 64'h77, 8'hFF, 64'd0, 2'b11, 18);
        wait_idle();
        chk("t6_timeout_err", timeout_err, 1);
        no_b = 0;
        issue(1, 32'h2000_0408, 64'h78, 8'hFF, 64'd0, 2'b00, 3);
        wait_idle();
        chk("t6_timeout_sticky", timeout_err, 1);
`else
        chk("timeout_err_tied", timeout_err, 0);
`endif

        repeat (3) @(negedge CLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

endmodule
